mem_loader: RTL and testbench



---
 rtl/mem_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: host-side sequencer for the CPU's external memory ports.
// Streams a program into instruction memory and initial data into data
// memory, runs the CPU for a fixed number of cycles, then streams a block
// of data memory back out. Every output is driven straight from a register.
module mem_loader #(
   parameter int CNT_W     = 16,
   parameter int RUN_W     = 24,
   parameter int ADDR_STEP = 4
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] imem_words,
   input  logic [CNT_W-1:0] dmem_words,
   input  logic [RUN_W-1:0] run_cycles,
   input  logic [CNT_W-1:0] dump_words,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic [31:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   output logic [31:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [31:0]      wdata_ext_2,
   input  logic [31:0]      rdata_ext_2,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, FIN
   } state_t;

   localparam logic [31:0]      STEP = 32'(ADDR_STEP);
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d, ns;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] imem_q, imem_d, dmem_q, dmem_d, dump_q, dump_d;
   logic [RUN_W-1:0] run_q, run_d, run_cnt_q, run_cnt_d;
   logic             s_ready_q, s_ready_d, m_valid_q, m_valid_d;
   logic [31:0]      m_data_q, m_data_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0]      addr2_q, addr2_d, wdata2_q, wdata2_d;
   logic             wen_q, wen_d, wen2_q, wen2_d, ren2_q, ren2_d;
   logic             en_q, en_d, busy_q, busy_d, done_q, done_d;
   logic             enter, allow_ren;

   // First phase after 'cur' whose count is non-zero; FIN when none remain.
   function automatic state_t next_phase(input state_t cur, input logic has_i,
                                         input logic has_d, input logic has_r,
                                         input logic has_u);
      state_t r;
      r = FIN;
      if (has_u && (cur inside {IDLE, LOAD_I, LOAD_D, RUN})) r = DUMP_RD;
      if (has_r && (cur inside {IDLE, LOAD_I, LOAD_D}))      r = RUN;
      if (has_d && (cur inside {IDLE, LOAD_I}))              r = LOAD_D;
      if (has_i && (cur == IDLE))                            r = LOAD_I;
      return r;
   endfunction

   function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] i);
      return 32'(i) * STEP;
   endfunction

   // Next-state and next-output computation for the whole session sequencer.
   always_comb begin
      ns        = state_q;
      enter     = 1'b0;
      allow_ren = 1'b1;
      idx_d     = idx_q;
      imem_d    = imem_q;
      dmem_d    = dmem_q;
      run_d     = run_q;
      dump_d    = dump_q;
      run_cnt_d = run_cnt_q;
      s_ready_d = s_ready_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      addr2_d   = addr2_q;
      wdata2_d  = wdata2_q;
      wen_d     = 1'b0;
      wen2_d    = 1'b0;
      ren2_d    = 1'b0;
      en_d      = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               imem_d = imem_words;
               dmem_d = dmem_words;
               run_d  = run_cycles;
               dump_d = dump_words;
               idx_d  = '0;
               ns     = next_phase(IDLE, |imem_words, |dmem_words,
                                   |run_cycles, |dump_words);
               enter  = 1'b1;
            end
         end
         LOAD_I: begin
            if (s_valid && s_ready_q) begin
               wen_d   = 1'b1;
               wdata_d = s_data;
               addr_d  = word_addr(idx_q);
               if (idx_q == imem_q - ONE) begin
                  idx_d = '0;
                  ns    = next_phase(LOAD_I, 1'b0, |dmem_q, |run_q, |dump_q);
                  enter = 1'b1;
               end else begin
                  idx_d = idx_q + ONE;
               end
            end
         end
         LOAD_D: begin
            // The final write pulse on the _2 port overlaps the next state's
            // first cycle, so a following read must wait one cycle.
            allow_ren = 1'b0;
            if (s_valid && s_ready_q) begin
               wen2_d   = 1'b1;
               wdata2_d = s_data;
               addr2_d  = word_addr(idx_q);
               if (idx_q == dmem_q - ONE) begin
                  idx_d = '0;
                  ns    = next_phase(LOAD_D, 1'b0, 1'b0, |run_q, |dump_q);
                  enter = 1'b1;
               end else begin
                  idx_d = idx_q + ONE;
               end
            end
         end
         RUN: begin
            if (run_cnt_q != run_q) begin
               en_d      = 1'b1;
               run_cnt_d = run_cnt_q + 1'b1;
            end else begin
               ns    = next_phase(RUN, 1'b0, 1'b0, 1'b0, |dump_q);
               enter = 1'b1;
            end
         end
         DUMP_RD: begin
            if (!ren2_q) begin
               ren2_d  = 1'b1;
               addr2_d = word_addr(idx_q);
            end else begin
               ns = DUMP_WAIT;
            end
         end
         DUMP_WAIT: begin
            m_data_d  = rdata_ext_2;
            m_valid_d = 1'b1;
            ns        = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (idx_q == dump_q - ONE) begin
                  idx_d = '0;
                  ns    = FIN;
                  enter = 1'b1;
               end else begin
                  idx_d   = idx_q + ONE;
                  ns      = DUMP_RD;
                  ren2_d  = 1'b1;
                  addr2_d = word_addr(idx_q + ONE);
               end
            end
         end
         FIN: begin
            ns = IDLE;
         end
         default: ns = IDLE;
      endcase
      if (enter) begin
         s_ready_d = (ns inside {LOAD_I, LOAD_D});
         run_cnt_d = '0;
         if (ns == DUMP_RD && allow_ren) begin
            ren2_d  = 1'b1;
            addr2_d = '0;
         end
         if (ns == FIN) done_d = 1'b1;
      end
      state_d = ns;
      busy_d  = (ns != IDLE);
   end

   // State and output registers; reset aborts any session immediately.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         imem_q    <= '0;
         dmem_q    <= '0;
         run_q     <= '0;
         dump_q    <= '0;
         run_cnt_q <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         addr2_q   <= '0;
         wdata2_q  <= '0;
         wen_q     <= 1'b0;
         wen2_q    <= 1'b0;
         ren2_q    <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         imem_q    <= imem_d;
         dmem_q    <= dmem_d;
         run_q     <= run_d;
         dump_q    <= dump_d;
         run_cnt_q <= run_cnt_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         addr2_q   <= addr2_d;
         wdata2_q  <= wdata2_d;
         wen_q     <= wen_d;
         wen2_q    <= wen2_d;
         ren2_q    <= ren2_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign addr_ext    = addr_q;
   assign wen_ext     = wen_q;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = wdata_q;
   assign addr_ext_2  = addr2_q;
   assign wen_ext_2   = wen2_q;
   assign ren_ext_2   = ren2_q;
   assign wdata_ext_2 = wdata2_q;
   assign cpu_enable  = en_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a table of sessions plus hand-written
// reset-abort and start-while-busy sequences, with a small data memory model.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] imem_words = '0, dmem_words = '0, dump_words = '0;
   logic [23:0] run_cycles = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic [31:0] rdata_ext_2 = '0;
   logic        cpu_enable, busy, done;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:63];

   typedef struct packed {
      int          im, dm, rc, dw;
      bit          rnd;
      int          sa, sl;
      logic [31:0] ibase, dbase, dstep;
      int          exp_wi, exp_wd, exp_en, exp_dn;
      logic [31:0] exp_d0, exp_d1, exp_d2;
   } vec_t;

   vec_t vecs [7];

   mem_loader dut (
      .clk(clk), .arst_n(arst_n), .start(start),
      .imem_words(imem_words), .dmem_words(dmem_words),
      .run_cycles(run_cycles), .dump_words(dump_words),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
      .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
      .rdata_ext_2(rdata_ext_2), .cpu_enable(cpu_enable), .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Data memory model: synchronous write, one-cycle read latency.
   always @(posedge clk) begin
      if (wen_ext_2) mem[addr_ext_2[7:2]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[7:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wordk(input vec_t v, input int k);
      if (k < v.im) return v.ibase + 32'(k);
      return v.dbase + 32'(k - v.im) * v.dstep;
   endfunction

   function automatic logic [31:0] expdump(input vec_t v, input int n);
      if (n == 0) return v.exp_d0;
      if (n == 1) return v.exp_d1;
      return v.exp_d2;
   endfunction

   task automatic run_row(input int id, input vec_t v, input int restart_at);
      int k = 0, wi = 0, wd = 0, en_cyc = 0, rises = 0, done_n = 0;
      int dump_n = 0, cyc = 0, lat = -1, viol = 0, stall_left = 0, after = -1;
      bit stalled = 0, hold_chk = 0, prev_en = 0, fin = 0;
      logic [31:0] held = '0;
      @(negedge clk);
      imem_words = 16'(v.im); dmem_words = 16'(v.dm);
      run_cycles = 24'(v.rc); dump_words = 16'(v.dw);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin && cyc < 3000) begin
         // memory-port observation
         if (wen_ext) begin
            chk("imem_addr", addr_ext, 32'(wi * 4));
            chk("imem_data", wdata_ext, wordk(v, wi));
            wi++;
         end
         if (wen_ext_2) begin
            chk("dmem_addr", addr_ext_2, 32'(wd * 4));
            chk("dmem_data", wdata_ext_2, wordk(v, v.im + wd));
            wd++;
         end
         if (cpu_enable) begin
            en_cyc++;
            if (!prev_en) rises++;
            if (wen_ext || wen_ext_2 || ren_ext_2 || ren_ext) viol++;
         end
         if (wen_ext_2 && ren_ext_2) viol++;
         prev_en = cpu_enable;
         if (done) begin
            done_n++;
            if (lat < 0) lat = cyc;
            if (after < 0) after = cyc;
         end
         // output stream sink with an optional stall
         if (hold_chk && m_valid) chk("m_hold", m_data, held);
         if (m_valid && dump_n == v.sa && !stalled && v.sl > 0) begin
            stalled = 1;
            stall_left = v.sl;
         end
         m_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         hold_chk = m_valid && !m_ready;
         held = m_data;
         if (m_valid && m_ready) begin
            if (dump_n < 3) chk("dump_data", m_data, expdump(v, dump_n));
            dump_n++;
         end
         // input stream source; keeps offering words past the loads
         s_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data = (k < v.im + v.dm) ? wordk(v, k) : 32'hBAD0_0000 + 32'(k);
         if (s_valid && s_ready) k++;
         // optional start pulse while the session is busy
         if (restart_at > 0 && cyc == restart_at) begin
            imem_words = 16'd5; dmem_words = 16'd5;
            run_cycles = 24'd3; dump_words = 16'd2;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (after >= 0 && cyc >= after + 2) fin = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      start = 1'b0;
      chk("done_seen", 32'(done_n > 0), 32'd1);
      chk("done_count", 32'(done_n), 32'd1);
      chk("handshakes", 32'(k), 32'(v.exp_wi + v.exp_wd));
      chk("imem_writes", 32'(wi), 32'(v.exp_wi));
      chk("dmem_writes", 32'(wd), 32'(v.exp_wd));
      chk("run_cycles", 32'(en_cyc), 32'(v.exp_en));
      chk("run_bursts", 32'(rises), 32'(v.exp_en > 0));
      chk("port_overlap", 32'(viol), 32'd0);
      chk("dump_words", 32'(dump_n), 32'(v.exp_dn));
      chk("busy_end", 32'(busy), 32'd0);
      chk("s_ready_end", 32'(s_ready), 32'd0);
      if (v.im == 0 && v.dm == 0 && v.rc == 0 && v.dw == 0)
         chk("done_latency", 32'(lat <= 1), 32'd1);
      $display("session %0d: im=%0d dm=%0d run=%0d dump=%0d hs=%0d en=%0d dumped=%0d done=%0d",
               id, v.im, v.dm, v.rc, v.dw, k, en_cyc, dump_n, done_n);
   endtask

   initial begin
      vec_t rv;
      bit seen;
      //          im dm rc dw rnd sa sl ibase          dbase          dstep  wi wd en dn d0             d1             d2
      vecs[0] = '{3, 2, 0, 0, 1'b0, -1, 0, 32'hA0,        32'hD0,        32'h1,  3, 2, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[1] = '{4, 0, 0, 0, 1'b1, -1, 0, 32'h1001,      32'h0,         32'h0,  4, 0, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[2] = '{0, 0, 10, 0, 1'b0, -1, 0, 32'h0,        32'h0,         32'h0,  0, 0, 10, 0, 32'h0,        32'h0,         32'h0};
      vecs[3] = '{0, 3, 0, 3, 1'b0, 1, 5, 32'h0,          32'h11,        32'h11, 0, 3, 0, 3, 32'h11,        32'h22,        32'h33};
      vecs[4] = '{0, 0, 0, 0, 1'b0, -1, 0, 32'h0,         32'h0,         32'h0,  0, 0, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[5] = '{2, 2, 5, 2, 1'b0, -1, 0, 32'h1111_0000, 32'hD5D5_0000, 32'h1,  2, 2, 5, 2, 32'hD5D5_0000, 32'hD5D5_0001, 32'h0};
      vecs[6] = '{1, 0, 0, 1, 1'b0, -1, 0, 32'h7777_7777, 32'h0,         32'h0,  1, 0, 0, 1, 32'hD5D5_0000, 32'h0,         32'h0};

      // reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'(|{s_ready, m_valid, m_data, addr_ext, wen_ext, ren_ext,
                                  wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2,
                                  wdata_ext_2, cpu_enable, busy, done}), 32'd0);
      arst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_row(i, vecs[i], 0);

      // start pulses during a run must be ignored
      rv = vecs[2];
      rv.rc = 20;
      rv.exp_en = 20;
      run_row(7, rv, 5);

      // reset asserted during RUN aborts the session
      @(negedge clk);
      imem_words = 16'd0; dmem_words = 16'd0; run_cycles = 24'd50; dump_words = 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (cpu_enable) seen = 1;
         else @(negedge clk);
      end
      chk("run_reached", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      chk("abort_outputs", 32'(|{s_ready, m_valid, m_data, addr_ext, wen_ext, ren_ext,
                                  wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2,
                                  wdata_ext_2, cpu_enable, busy, done}), 32'd0);
      @(negedge clk);
      chk("abort_held", 32'({busy, cpu_enable}), 32'd0);
      arst_n = 1'b1;
      $display("reset abort during RUN applied");
      run_row(8, vecs[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
